// File: rtl/fc_mac_if.sv
// fc_mac_if -- bundle of the fc_mac data streams.
//
// Stream 0 carries one signed activation per beat, stream 1 carries the
// matching per-class weight vector plus the bias vector. Both streams share
// a single ready (ready0_o == ready1_o), so a beat moves only when both
// valids are high together. The result stream carries one packed vector of
// per-class sums per packet.
//
// Handshake rule (all three streams): a transfer happens on a rising clk
// edge where valid and ready are both high. A source keeps its payload
// stable while valid is high and not yet accepted; ready may change freely.
//
// Modports:
//   slave  -- the fc_mac datapath (consumes streams 0/1, produces results)
//   master -- whoever feeds the streams and drains the results
interface fc_mac_if #(
  parameter int I_BW        = 8,
  parameter int BIAS_BW     = 2 * I_BW,
  parameter int O_BW        = 3 * I_BW,
  parameter int NUM_CLASSES = 3
);
  logic [I_BW-1:0]               data0_i;
  logic                          valid0_i;
  logic                          last0_i;
  logic                          ready0_o;

  logic [NUM_CLASSES*I_BW-1:0]    data1_w_i;
  logic [NUM_CLASSES*BIAS_BW-1:0] data1_b_i;
  logic                          valid1_i;
  logic                          last1_i;
  logic                          ready1_o;

  logic [NUM_CLASSES*O_BW-1:0]    data_o;
  logic                          valid_o;
  logic                          last_o;
  logic                          ready_i;

  modport slave (
    input  data0_i, valid0_i, last0_i,
    input  data1_w_i, data1_b_i, valid1_i, last1_i,
    input  ready_i,
    output ready0_o, ready1_o,
    output data_o, valid_o, last_o
  );

  modport master (
    output data0_i, valid0_i, last0_i,
    output data1_w_i, data1_b_i, valid1_i, last1_i,
    output ready_i,
    input  ready0_o, ready1_o,
    input  data_o, valid_o, last_o
  );
endinterface

// File: rtl/fc_mac.sv
// fc_mac -- fully-connected multiply-accumulate over NUM_CLASSES lanes.
//
// Each accepted beat multiplies the activation by every lane weight; the
// products are summed per lane until the beat flagged with last1_i. Two
// drain cycles later the bias is added and the vector is presented on the
// result stream as a single-beat packet. A packet that stalls for
// TIMEOUT_CYCLES idle cycles is discarded without producing output.
//
// Optional feature macro: FC_MAC_SAT_EN -- when defined, the accumulate
// and bias additions saturate per lane; otherwise they wrap modulo 2^O_BW.
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset
//   bus      fc_mac_if.slave (activation, weights/bias, result streams)
//   state_o  current FSM state (debug observation)
module fc_mac #(
  parameter int I_BW           = 8,
  parameter int BIAS_BW        = 2 * I_BW,
  parameter int O_BW           = 3 * I_BW,
  parameter int NUM_CLASSES    = 3,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fc_mac_if.slave     bus,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam int P_BW = 2 * I_BW;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  state_t                    state_q;
  logic                      ready_q;
  logic                      valid_q;
  logic                      drain_q;
  logic [TO_W-1:0]           to_cnt_q;
  logic                      has_data_q;
  logic                      prod_vld_q;
  logic signed [P_BW-1:0]    prod_q [NUM_CLASSES];
  logic signed [O_BW-1:0]    acc_q  [NUM_CLASSES];
  logic signed [BIAS_BW-1:0] bias_q [NUM_CLASSES];
  logic [NUM_CLASSES*O_BW-1:0] data_q;

  logic                      accept;
  logic                      flush;
  logic                      out_done;
  logic signed [P_BW-1:0]    prod_d [NUM_CLASSES];

  // Lane addition: saturating or wrapping depending on the build.
  function automatic logic signed [O_BW-1:0] add_o(
    input logic signed [O_BW-1:0] a,
    input logic signed [O_BW-1:0] b
  );
`ifdef FC_MAC_SAT_EN
    logic signed [O_BW:0] s;
    s = {a[O_BW-1], a} + {b[O_BW-1], b};
    // Sign bits disagree only when the true sum left the O_BW range.
    if (s[O_BW] != s[O_BW-1]) begin
      return s[O_BW] ? {1'b1, {(O_BW-1){1'b0}}} : {1'b0, {(O_BW-1){1'b1}}};
    end
    return s[O_BW-1:0];
`else
    return a + b;
`endif
  endfunction

  assign accept   = bus.valid0_i & bus.valid1_i & ready_q;
  // Counter at its limit implies the previous cycle had no accept, so the
  // product pipe is already empty and only the accumulators need zeroing.
  assign flush    = (state_q == ACCUM) && has_data_q && (to_cnt_q == TO_MAX);
  assign out_done = (state_q == OUTPUT) && bus.ready_i;

  always_comb begin
    for (int k = 0; k < NUM_CLASSES; k++) begin
      prod_d[k] = '0;
      prod_d[k] = P_BW'($signed(bus.data0_i)) *
                  P_BW'($signed(bus.data1_w_i[k*I_BW +: I_BW]));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ACCUM;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      drain_q    <= 1'b0;
      to_cnt_q   <= '0;
      has_data_q <= 1'b0;
      prod_vld_q <= 1'b0;
      data_q     <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
        bias_q[k] <= '0;
      end
    end else begin
      prod_vld_q <= accept;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (accept) begin
          prod_q[k] <= prod_d[k];
        end else if (flush) begin
          prod_q[k] <= '0;
        end
        if (flush || out_done) begin
          acc_q[k] <= '0;
        end else if (prod_vld_q) begin
          acc_q[k] <= add_o(acc_q[k], O_BW'(prod_q[k]));
        end
      end

      case (state_q)
        ACCUM: begin
          if (accept && bus.last1_i) begin
            state_q    <= DRAIN;
            ready_q    <= 1'b0;
            drain_q    <= 1'b0;
            to_cnt_q   <= '0;
            has_data_q <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
              bias_q[k] <= bus.data1_b_i[k*BIAS_BW +: BIAS_BW];
            end
          end else begin
            if (accept) begin
              to_cnt_q <= '0;
            end else if (to_cnt_q != TO_MAX) begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
            has_data_q <= accept | (has_data_q & ~flush);
          end
        end
        DRAIN: begin
          // Two cycles let the last product land in the accumulator.
          if (drain_q) begin
            state_q <= OUTPUT;
            valid_q <= 1'b1;
            for (int k = 0; k < NUM_CLASSES; k++) begin
              data_q[k*O_BW +: O_BW] <= add_o(acc_q[k], O_BW'(bias_q[k]));
            end
          end else begin
            drain_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.ready_i) begin
            state_q <= ACCUM;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready0_o = ready_q;
  assign bus.ready1_o = ready_q;
  assign bus.valid_o  = valid_q;
  assign bus.last_o   = valid_q;
  assign bus.data_o   = data_q;
  assign state_o      = state_q;

  // The two streams must agree on where a packet ends.
  last_agree_a: assert property (@(posedge clk_i) disable iff (rst_i)
    accept |-> (bus.last0_i == bus.last1_i));

endmodule

// File: tb/tb_fc_mac.sv
// tb_fc_mac -- directed self-checking bench for fc_mac.
// Build: I_BW=8, BIAS_BW=16, O_BW=16, NUM_CLASSES=3, TIMEOUT_CYCLES=8.
// Honors FC_MAC_SAT_EN for the macro-dependent expected values.
module tb_fc_mac;
  localparam int I_BW = 8;
  localparam int BIAS_BW = 16;
  localparam int O_BW = 16;
  localparam int NC = 3;
  localparam int TO = 8;
  localparam int OW = NC * O_BW;

`ifdef FC_MAC_SAT_EN
  localparam int EXP_OVF  = 32767;   // 3*127*127 clamps, then +32767 clamps
  localparam int EXP_BIAS = -32768;  // -1 + -32768 clamps low
`else
  localparam int EXP_OVF  = 15618;   // (48387 + 32767) mod 2^16, signed
  localparam int EXP_BIAS = 32767;   // -32769 wraps
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] state;
  int cyc = 0;
  int last_acc_cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [OW-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_mac_if #(.I_BW(I_BW), .BIAS_BW(BIAS_BW), .O_BW(O_BW), .NUM_CLASSES(NC)) bus ();

  fc_mac #(
    .I_BW(I_BW), .BIAS_BW(BIAS_BW), .O_BW(O_BW),
    .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*I_BW-1:0] pw(input int a, input int b, input int c);
    logic [NC*I_BW-1:0] r;
    r[0*I_BW +: I_BW] = I_BW'(a);
    r[1*I_BW +: I_BW] = I_BW'(b);
    r[2*I_BW +: I_BW] = I_BW'(c);
    return r;
  endfunction

  function automatic logic [NC*BIAS_BW-1:0] pb(input int a, input int b, input int c);
    logic [NC*BIAS_BW-1:0] r;
    r[0*BIAS_BW +: BIAS_BW] = BIAS_BW'(a);
    r[1*BIAS_BW +: BIAS_BW] = BIAS_BW'(b);
    r[2*BIAS_BW +: BIAS_BW] = BIAS_BW'(c);
    return r;
  endfunction

  function automatic logic [OW-1:0] po(input int a, input int b, input int c);
    logic [OW-1:0] r;
    r[0*O_BW +: O_BW] = O_BW'(a);
    r[1*O_BW +: O_BW] = O_BW'(b);
    r[2*O_BW +: O_BW] = O_BW'(c);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(bus.data_o), 64'hdead);
      end else begin
        check("out_data", 64'(bus.data_o), 64'(exp_q.pop_front()));
        check("out_last", 64'(bus.last_o), 64'd1);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_beat(input int d, input logic [NC*I_BW-1:0] w,
                          input logic [NC*BIAS_BW-1:0] b, input logic last);
    bus.data0_i   = I_BW'(d);
    bus.data1_w_i = w;
    bus.data1_b_i = b;
    bus.valid0_i  = 1'b1;
    bus.valid1_i  = 1'b1;
    bus.last0_i   = last;
    bus.last1_i   = last;
  endtask

  task automatic clear_beat();
    bus.valid0_i = 1'b0;
    bus.valid1_i = 1'b0;
    bus.last0_i  = 1'b0;
    bus.last1_i  = 1'b0;
  endtask

  // Presents one beat, waits (bounded) for ready, returns just after the
  // accepting edge with the valids dropped.
  task automatic send_beat(input int d, input logic [NC*I_BW-1:0] w,
                           input logic [NC*BIAS_BW-1:0] b, input logic last);
    int n;
    set_beat(d, w, b, last);
    n = 0;
    @(negedge clk);
    while (!bus.ready0_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", 64'(bus.ready0_o), 64'd1);
    last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    clear_beat();
  endtask

  task automatic wait_valid(output int seen);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("valid_rise", 64'(bus.valid_o), 64'd1);
    seen = cyc;
  endtask

  task automatic send_ref_packet();
    for (int i = 1; i <= 4; i++) begin
      send_beat(i, pw(1, -2, 0), pb(10, -5, 7), i == 4);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    bus.data0_i = '0;
    bus.data1_w_i = '0;
    bus.data1_b_i = '0;
    bus.ready_i = 1'b1;
    clear_beat();
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_last", 64'(bus.last_o), 64'd0);
    check("rst_data", 64'(bus.data_o), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_ready0", 64'(bus.ready0_o), 64'd1);
    check("rel_ready1", 64'(bus.ready1_o), 64'd1);
    @(posedge clk);
    #1;

    // Reference 4-beat packet, then a back-to-back packet hitting the
    // product extremes and the most negative bias.
    exp_q.push_back(po(20, -25, 7));
    send_ref_packet();
    wait_valid(seen);
    check("latency", 64'(seen - last_acc_cyc), 64'd3);
    @(posedge clk);
    #1;
    exp_q.push_back(po(128, -127, EXP_BIAS));
    send_beat(-128, pw(-128, 127, 1), pb(0, 0, -32768), 1'b0);
    send_beat(127, pw(-128, 127, 1), pb(0, 0, -32768), 1'b1);
    wait_valid(seen);
    check("latency_b2b", 64'(seen - last_acc_cyc), 64'd3);
    @(posedge clk);
    #1;

    // Back-pressure: result held while ready_i low, a waiting single-beat
    // packet is refused until the result drains.
    bus.ready_i = 1'b0;
    exp_q.push_back(po(-4, -2, 8));
    send_beat(2, pw(3, 4, -5), pb(-1, 2, 3), 1'b0);
    send_beat(-3, pw(3, 4, -5), pb(-1, 2, 3), 1'b1);
    wait_valid(seen);
    exp_q.push_back(po(85, 20, -381));
    set_beat(-3, pw(5, -7, 127), pb(100, -1, 0), 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(bus.valid_o), 64'd1);
      check("hold_data", 64'(bus.data_o), 64'(po(-4, -2, 8)));
      check("hold_ready0", 64'(bus.ready0_o), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ready_after_out", 64'(bus.ready0_o), 64'd1);
    @(posedge clk);
    #1 clear_beat();
    wait_valid(seen);
    @(posedge clk);
    #1;

    // Partial packet abandoned by timeout, then a fresh 1-beat packet.
    exp_q.push_back(po(7, 0, 0));
    send_beat(5, pw(1, 1, 1), pb(0, 0, 0), 1'b0);
    send_beat(6, pw(1, 1, 1), pb(0, 0, 0), 1'b0);
    repeat (TO) @(posedge clk);
    #1;
    send_beat(3, pw(2, 0, 0), pb(1, 0, 0), 1'b1);
    wait_valid(seen);
    @(posedge clk);
    #1;

    // Accumulator and bias overflow.
    exp_q.push_back(po(EXP_OVF, 0, 0));
    for (int i = 0; i < 3; i++) begin
      send_beat(127, pw(127, 0, 0), pb(32767, 0, 0), i == 2);
    end
    wait_valid(seen);
    @(posedge clk);
    #1;

    // Reset while draining: nothing may come out, next packet is clean.
    send_beat(9, pw(9, 9, 9), pb(9, 9, 9), 1'b0);
    send_beat(9, pw(9, 9, 9), pb(9, 9, 9), 1'b1);
    check("drain_state", 64'(state), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.ready0_o), 64'd1);
    check("post_rst_data", 64'(bus.data_o), 64'd0);
    check("post_rst_state", 64'(state), 64'd0);
    repeat (8) @(negedge clk);
    check("post_rst_no_valid", 64'(bus.valid_o), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(po(20, -25, 7));
    send_ref_packet();
    wait_valid(seen);
    check("latency_post_rst", 64'(seen - last_acc_cyc), 64'd3);

    repeat (6) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
